// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding as seen on seq_state.
package reset_seq_pkg;

  localparam int unsigned SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  // States in which losing PLL lock must restart the whole sequence.
  function automatic logic needs_lock(input seq_state_e s);
    return (s == ST_HOLD) || (s == ST_RELEASE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Parametrised-width two-flop synchroniser with a synchronous reset to RESET_VAL.
module reset_seq_sync #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Global reset sequencer: PLL reset, lock wait, hold, then ordered stage releases.
// Optional lock timeout/retry is built when RESET_SEQ_LOCK_TIMEOUT_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SOURCES_WIDTH = 2,
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned STAGES        = 3,
  parameter int unsigned STAGE_GAP     = 256,
  parameter int unsigned PLL_HOLD      = 16,
  parameter int unsigned TIMEOUT_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SOURCES_WIDTH-1:0] resetn_sources,
  input  logic [SOURCES_WIDTH-1:0] source_mask,
  input  logic                     sw_reset_req,
  input  logic                     pll_locked,
  output logic                     pll_resetn,
  output logic [STAGES-1:0]        stage_resetn,
  output logic                     all_released,
  output logic                     lock_timeout,
  output logic [SEQ_STATE_W-1:0]   seq_state
);

  localparam int unsigned PLL_CNT_W = $clog2(PLL_HOLD);
  localparam int unsigned GAP_CNT_W = $clog2(STAGE_GAP + 1);
  localparam int unsigned IDX_W     = $clog2(STAGES + 1);

  localparam logic [PLL_CNT_W-1:0] PLL_LAST  = PLL_CNT_W'(PLL_HOLD - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST  = GAP_CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(STAGES - 1);
  localparam logic [IDX_W-1:0]     IDX_FIRST = IDX_W'(1);

  if (PLL_HOLD < 2 || STAGE_GAP < 1 || STAGES < 1 || COUNTER_WIDTH < 1 ||
      TIMEOUT_WIDTH < 1) begin : g_param_check
    $error("reset_sequencer: illegal parameter set");
  end

  seq_state_e                 state;
  logic [PLL_CNT_W-1:0]       pll_cnt;
  logic [COUNTER_WIDTH-1:0]   hold_cnt;
  logic [GAP_CNT_W-1:0]       gap_cnt;
  logic [IDX_W-1:0]           stage_idx;

  logic [SOURCES_WIDTH-1:0]   sources_sync;
  logic                       locked_sync;
  logic                       seq_req;
  logic                       lock_lost;

  // Sources synchronise to "not requesting" so leaving block reset does not
  // look like a fresh reset request.
  reset_seq_sync #(
    .WIDTH     (SOURCES_WIDTH),
    .RESET_VAL ({SOURCES_WIDTH{1'b1}})
  ) u_src_sync (
    .clk   (clk),
    .reset (reset),
    .d     (resetn_sources),
    .q     (sources_sync)
  );

  reset_seq_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_sync)
  );

  assign seq_req   = sw_reset_req | (|(~sources_sync & ~source_mask));
  assign lock_lost = ~locked_sync & needs_lock(state);
  assign seq_state = state;

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     lock_timeout_q;
  assign lock_timeout = lock_timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || seq_req || lock_lost) begin
      // Block reset and sequence restarts share one clear path; only block
      // reset clears the sticky timeout flag.
      state        <= ST_PLL_RST;
      pll_resetn   <= 1'b0;
      stage_resetn <= '0;
      all_released <= 1'b0;
      pll_cnt      <= '0;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
      stage_idx    <= '0;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
      tmo_cnt      <= '0;
      if (reset) begin
        lock_timeout_q <= 1'b0;
      end
`endif
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (pll_cnt == PLL_LAST) begin
            state      <= ST_WAIT_LOCK;
            pll_resetn <= 1'b1;
            pll_cnt    <= '0;
          end else begin
            pll_cnt <= pll_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_sync) begin
            state <= ST_HOLD;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
          else if (&tmo_cnt) begin
            state          <= ST_PLL_RST;
            pll_resetn     <= 1'b0;
            lock_timeout_q <= 1'b1;
            tmo_cnt        <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_HOLD: begin
          if (&hold_cnt) begin
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            stage_resetn <= STAGES'(1);
            if (STAGES == 1) begin
              state        <= ST_RUN;
              all_released <= 1'b1;
            end else begin
              state     <= ST_RELEASE;
              stage_idx <= IDX_FIRST;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            // Shifting in ones keeps the release strictly in bit order.
            stage_resetn <= (stage_resetn << 1) | STAGES'(1);
            if (stage_idx == IDX_LAST) begin
              state        <= ST_RUN;
              all_released <= 1'b1;
              stage_idx    <= '0;
            end else begin
              stage_idx <= stage_idx + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          state <= ST_RUN;
        end

        default: begin
          state        <= ST_PLL_RST;
          pll_resetn   <= 1'b0;
          stage_resetn <= '0;
          all_released <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random disturbances
// checked every cycle against a milestone-based timeline model.
module tb_reset_sequencer;

  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned ST  = 3;
  localparam int unsigned GAP = 4;
  localparam int unsigned PH  = 8;
  localparam int unsigned TW  = 6;
  localparam int HOLD_CYC = 1 << CW;
  localparam int TMO_CYC  = 1 << TW;
  localparam int MAXC     = 4096;
  localparam logic [8:0] RUN_BUNDLE = 9'b1_111_1_0_100;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] resetn_sources;
  logic [SW-1:0] source_mask;
  logic          sw_reset_req;
  logic          pll_locked;
  logic          pll_resetn;
  logic [ST-1:0] stage_resetn;
  logic          all_released;
  logic          lock_timeout;
  logic [2:0]    seq_state;

  reset_sequencer #(
    .SOURCES_WIDTH (SW),
    .COUNTER_WIDTH (CW),
    .STAGES        (ST),
    .STAGE_GAP     (GAP),
    .PLL_HOLD      (PH),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .resetn_sources (resetn_sources),
    .source_mask    (source_mask),
    .sw_reset_req   (sw_reset_req),
    .pll_locked     (pll_locked),
    .pll_resetn     (pll_resetn),
    .stage_resetn   (stage_resetn),
    .all_released   (all_released),
    .lock_timeout   (lock_timeout),
    .seq_state      (seq_state)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;

  // Input history per clock edge; the synchronised views are derived from it.
  logic [SW-1:0] src_log  [MAXC];
  logic          lock_log [MAXC];
  logic          rst_log  [MAXC];

  // Timeline milestones: edge where PLL reset counting (re)started, edge where
  // WAIT_LOCK was entered, edge where HOLD was entered (-1 = not reached).
  int m_base = 0;
  int m_wait = -1;
  int m_hold = -1;
  bit m_tmo  = 1'b0;

  function automatic logic rst_at(input int k);
    return (k < 1) ? 1'b1 : rst_log[k];
  endfunction

  function automatic logic [SW-1:0] src_seen(input int k);
    return (rst_at(k - 1) || rst_at(k - 2)) ? {SW{1'b1}} : src_log[k - 2];
  endfunction

  function automatic logic lock_seen(input int k);
    return (rst_at(k - 1) || rst_at(k - 2)) ? 1'b0 : lock_log[k - 2];
  endfunction

  function automatic int phase_at(input int m);
    int k;
    if (m_hold >= 0) begin
      k = m - m_hold;
      if (k < HOLD_CYC) return 2;
      if (k < HOLD_CYC + int'(ST - 1) * int'(GAP)) return 3;
      return 4;
    end
    if (m_wait >= 0) return 1;
    return 0;
  endfunction

  function automatic logic [8:0] model_bundle();
    int ph;
    logic [ST-1:0] stg;
    ph = phase_at(n);
    for (int i = 0; i < int'(ST); i++)
      stg[i] = (m_hold >= 0) && (n >= m_hold + HOLD_CYC + i * int'(GAP));
    return {ph != 0, stg, ph == 4, m_tmo, 3'(ph)};
  endfunction

  function automatic logic [8:0] dut_bundle();
    return {pll_resetn, stage_resetn, all_released, lock_timeout, seq_state};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @edge %0d: observed %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_edge();
    int ph;
    logic req;
    logic lk;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: edge %0d exceeds %0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    src_log[n]  = resetn_sources;
    lock_log[n] = pll_locked;
    rst_log[n]  = reset;
    if (reset) begin
      m_base = n; m_wait = -1; m_hold = -1; m_tmo = 1'b0;
    end else begin
      ph  = phase_at(n - 1);
      lk  = lock_seen(n);
      req = sw_reset_req || (|(~src_seen(n) & ~source_mask));
      if (req || (!lk && ph >= 2)) begin
        m_base = n; m_wait = -1; m_hold = -1;
      end else if (ph == 0) begin
        if (n - m_base == int'(PH)) m_wait = n;
      end else if (ph == 1) begin
        if (lk) m_hold = n;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        else if (n - m_wait == TMO_CYC) begin
          m_tmo = 1'b1; m_base = n; m_wait = -1;
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check("cycle", dut_bundle(), model_bundle());
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, output int cyc);
    cyc = 0;
    while (seq_state !== st && cyc < limit) begin step(); cyc++; end
  endtask

  task automatic wait_stage(input logic [ST-1:0] v, input int limit, output int cyc);
    cyc = 0;
    while (stage_resetn !== v && cyc < limit) begin step(); cyc++; end
  endtask

  task automatic wait_pll_release(input int limit, output int cyc);
    cyc = 0;
    while (pll_resetn !== 1'b1 && cyc < limit) begin step(); cyc++; end
  endtask

  initial begin
    int cyc;
    reset = 1'b1; resetn_sources = 2'b11; source_mask = 2'b00;
    sw_reset_req = 1'b0; pll_locked = 1'b1;
    repeat (3) step();
    check("reset_state", dut_bundle(), 32'h0);

    // Power-up with lock held high.
    reset = 1'b0;
    wait_pll_release(40, cyc);
    check("pll_release_delay", cyc, PH);
    wait_state(3'd2, 20, cyc);
    check("hold_entry", seq_state, 3'd2);
    wait_stage(3'b001, 40, cyc);
    check("stage0_delay", cyc, HOLD_CYC);
    wait_stage(3'b011, 20, cyc);
    check("stage1_gap", cyc, GAP);
    wait_stage(3'b111, 20, cyc);
    check("stage2_gap", cyc, GAP);
    check("all_released_with_last", {all_released, seq_state}, {1'b1, 3'd4});

    // Masked then unmasked source pulse.
    source_mask = 2'b01; resetn_sources = 2'b10;
    step(); step();
    resetn_sources = 2'b11;
    repeat (4) step();
    check("masked_source", dut_bundle(), RUN_BUNDLE);
    source_mask = 2'b00; resetn_sources = 2'b10;
    step();
    resetn_sources = 2'b11;
    step(); step();
    check("unmasked_source", dut_bundle(), 32'h0);
    wait_state(3'd4, 80, cyc);
    check("rerun_after_source", seq_state, 3'd4);

    // Software request from RUN, then again mid-release.
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    check("sw_req_from_run", seq_state, 3'd0);
    wait_stage(3'b011, 80, cyc);
    check("reach_stage011", stage_resetn, 3'b011);
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    check("sw_req_abort", {stage_resetn, seq_state}, {3'b000, 3'd0});
    wait_state(3'd4, 80, cyc);
    check("rerun_after_sw", dut_bundle(), RUN_BUNDLE);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    step(); step();
    check("lock_drop_latency", seq_state, 3'd4);
    step();
    check("lock_drop", dut_bundle(), 32'h0);
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    wait_pll_release(40, cyc);
    check("retry_pll_release", cyc, PH);
    cyc = 0;
    while (lock_timeout !== 1'b1 && cyc < 200) begin step(); cyc++; end
    check("timeout_delay", cyc, TMO_CYC);
    check("timeout_restart", {pll_resetn, seq_state}, {1'b0, 3'd0});
    pll_locked = 1'b1;
    wait_pll_release(40, cyc);
    check("retry_hold_len", cyc, PH);
    wait_state(3'd4, 120, cyc);
    check("timeout_sticky", {lock_timeout, all_released}, 2'b11);
`else
    wait_state(3'd1, 40, cyc);
    check("wait_lock_entry", seq_state, 3'd1);
    repeat (TMO_CYC + 10) step();
    check("no_timeout", {lock_timeout, seq_state}, {1'b0, 3'd1});
    pll_locked = 1'b1;
    wait_state(3'd4, 120, cyc);
    check("run_after_late_lock", seq_state, 3'd4);
`endif

    // Random disturbances, model-checked every cycle.
    for (int c = 0; c < 600; c++) begin
      sw_reset_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) resetn_sources = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0) resetn_sources = 2'b11;
      if ($urandom_range(0, 99) == 0) source_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 89) == 0) pll_locked = ~pll_locked;
      step();
    end

    // Block reset in the middle of HOLD.
    resetn_sources = 2'b11; pll_locked = 1'b1;
    sw_reset_req = 1'b1; step(); sw_reset_req = 1'b0;
    wait_state(3'd2, 300, cyc);
    check("hold_before_reset", seq_state, 3'd2);
    repeat (5) step();
    reset = 1'b1; step();
    check("reset_mid_hold", dut_bundle(), 32'h0);
    step();
    reset = 1'b0;
    wait_state(3'd4, 120, cyc);
    check("run_after_reset", dut_bundle(), RUN_BUNDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
